// File: rtl/frame_pkg.sv
// Shared definitions for the frame parser and the frame dispatcher:
// field widths, the FIFO word layout and the dispatch state encoding.
package frame_pkg;

    localparam int DATA_W    = 16;
    localparam int CH_W      = 8;
    localparam int CNT_W     = 4;
    localparam int MAX_WORDS = 8;
    localparam int FIFO_W    = DATA_W * MAX_WORDS + CH_W + CNT_W;

    localparam logic [31:0] HEADER = 32'hE0E0_E0E0;
    localparam logic [31:0] TAIL   = 32'h0E0E_0E0E;

    typedef struct packed {
        logic [127:0] data;
        logic [7:0]   ch;
        logic [3:0]   cnt;
    } frame_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_DROP
    } dispatch_state_t;

endpackage

// File: rtl/frame_dispatch.sv
// Pops one frame at a time from the parser FIFO and replays its payload as
// 16-bit valid/ready beats on the one-hot channel named in the entry.
module frame_dispatch
    import frame_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_r_enable,
    input  logic [FIFO_W-1:0] data_from_fifo,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic [CH_W-1:0]   ch_sel,
    output logic              frame_last,
    output logic              frame_err,
    output logic              busy
);

    dispatch_state_t r_state;
    dispatch_state_t w_next;

    logic [DATA_W*MAX_WORDS-1:0] r_payload;
    logic [CH_W-1:0]             r_ch;
    logic [CNT_W-1:0]            r_idx;

    frame_word_t w_word;
    logic        w_entry_ok;
    logic        w_xfer;
    logic [6:0]  w_beat_base;

    assign w_word      = data_from_fifo;
    assign w_entry_ok  = $onehot(w_word.ch) && (w_word.cnt != '0) &&
                         (w_word.cnt <= CNT_W'(MAX_WORDS));
    assign w_xfer      = (r_state == ST_SEND) && data_out_ready;
    // idx never exceeds MAX_WORDS-1, so its low three bits select the beat.
    assign w_beat_base = {r_idx[2:0], 4'b0000};

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_payload <= '0;
            r_ch      <= '0;
            r_idx     <= '0;
        end else if (r_state == ST_LOAD) begin
            r_payload <= w_word.data;
            r_ch      <= w_word.ch;
            if (w_entry_ok) begin
                r_idx <= w_word.cnt - CNT_W'(1);
            end
        end else if (w_xfer && (r_idx != '0)) begin
            r_idx <= r_idx - CNT_W'(1);
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (!fifo_empty) w_next = ST_FETCH;
            ST_FETCH: w_next = ST_LOAD;
            ST_LOAD:  w_next = w_entry_ok ? ST_SEND : ST_DROP;
            ST_SEND:  if (w_xfer && (r_idx == '0)) w_next = ST_IDLE;
            ST_DROP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_r_enable  = 1'b0;
        data_out       = '0;
        data_out_valid = 1'b0;
        ch_sel         = '0;
        frame_last     = 1'b0;
        frame_err      = 1'b0;
        busy           = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: fifo_r_enable = !fifo_empty && !rst;
            ST_SEND: begin
                data_out       = r_payload[w_beat_base +: DATA_W];
                data_out_valid = 1'b1;
                ch_sel         = r_ch;
                frame_last     = (r_idx == '0);
            end
            ST_DROP: frame_err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_frame_dispatch.sv
// Self-checking bench for frame_dispatch: a queue-based FIFO model feeds frames,
// and a beat-level reference queue predicts every transfer and error pulse.
module tb_frame_dispatch;
    import frame_pkg::*;

    logic              clk_in = 1'b0;
    logic              rst = 1'b1;
    logic              fifo_empty = 1'b1;
    logic              fifo_r_enable;
    logic [FIFO_W-1:0] data_from_fifo = '0;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;
    logic              data_out_ready = 1'b0;
    logic [CH_W-1:0]   ch_sel;
    logic              frame_last;
    logic              frame_err;
    logic              busy;

    frame_dispatch dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_r_enable  (fifo_r_enable),
        .data_from_fifo (data_from_fifo),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .ch_sel         (ch_sel),
        .frame_last     (frame_last),
        .frame_err      (frame_err),
        .busy           (busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] d;
        logic [7:0]  ch;
        logic        last;
    } beat_t;

    logic [FIFO_W-1:0] fifo_q[$];
    beat_t             exp_q[$];
    beat_t             mon_b;
    logic              pop_pending = 1'b0;
    int                n_compared = 0;
    int                n_mismatched = 0;
    int                n_xfer = 0;
    int                n_pop = 0;
    int                n_err = 0;
    int                exp_err = 0;
    logic              prev_stall = 1'b0;
    logic [15:0]       prev_d;
    logic [7:0]        prev_ch;
    logic              prev_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: beat k of n comes from payload[(n-1-k)*16 +: 16].
    task automatic push_frame(input logic [127:0] p, input logic [7:0] ch, input logic [3:0] cnt);
        beat_t b;
        int    n;
        fifo_q.push_back({p, ch, cnt});
        n = int'(cnt);
        if ($onehot(ch) && n >= 1 && n <= MAX_WORDS) begin
            for (int k = 0; k < n; k++) begin
                b.d    = p[(n - 1 - k) * 16 +: 16];
                b.ch   = ch;
                b.last = (k == n - 1);
                exp_q.push_back(b);
            end
        end else begin
            exp_err++;
        end
    endtask

    // FIFO model: a pop requested in one cycle presents data just after the edge.
    always @(posedge clk_in) begin
        #1;
        if (pop_pending) begin
            pop_pending = 1'b0;
            if (fifo_q.size() > 0) data_from_fifo = fifo_q.pop_front();
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    // Monitor: samples mid-cycle, scoreboards transfers and stall stability.
    always @(negedge clk_in) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (fifo_r_enable) begin
                check("ren_while_empty", 64'(fifo_empty), 64'd0);
                pop_pending = 1'b1;
                n_pop++;
            end
            if (frame_err) n_err++;
            if (prev_stall) begin
                check("hold_valid", 64'(data_out_valid), 64'd1);
                check("hold_data", 64'(data_out), 64'(prev_d));
                check("hold_ch", 64'(ch_sel), 64'(prev_ch));
                check("hold_last", 64'(frame_last), 64'(prev_last));
            end
            if (data_out_valid) begin
                if (data_out_ready) begin
                    n_xfer++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(data_out), 64'hDEAD_0000);
                    end else begin
                        mon_b = exp_q.pop_front();
                        check("beat_data", 64'(data_out), 64'(mon_b.d));
                        check("beat_ch", 64'(ch_sel), 64'(mon_b.ch));
                        check("beat_last", 64'(frame_last), 64'(mon_b.last));
                    end
                end
                prev_stall = !data_out_ready;
                prev_d     = data_out;
                prev_ch    = ch_sel;
                prev_last  = frame_last;
            end else begin
                prev_stall = 1'b0;
                check("idle_ch_sel", 64'(ch_sel), 64'd0);
            end
        end
    end

    // mode 0: ready=1, mode 1: ready pattern 1,0,0 repeating, mode 2: random ready.
    task automatic run_until_done(input int budget, input int mode);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk_in);
            #2;
            case (mode)
                0:       data_out_ready = 1'b1;
                1:       data_out_ready = (i % 3 == 0);
                default: data_out_ready = 1'($urandom_range(0, 1));
            endcase
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !pop_pending && !busy) break;
        end
        if (i == budget) check("drain_timeout", 64'd1, 64'd0);
        data_out_ready = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ren"}, 64'(fifo_r_enable), 64'd0);
        check({tag, "_data"}, 64'(data_out), 64'd0);
        check({tag, "_valid"}, 64'(data_out_valid), 64'd0);
        check({tag, "_ch"}, 64'(ch_sel), 64'd0);
        check({tag, "_last"}, 64'(frame_last), 64'd0);
        check({tag, "_err"}, 64'(frame_err), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          x0, p0, e0, lat;
        logic [127:0] pay;
        logic [7:0]   rch;
        logic [3:0]   rcnt;
        localparam logic [127:0] PAY1 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

        // Reset state
        repeat (3) @(posedge clk_in);
        #2;
        check_all_zero("reset");
        rst = 1'b0;
        data_out_ready = 1'b1;
        repeat (2) @(posedge clk_in);

        // 1: full 8-beat frame, ready held high
        x0 = n_xfer;
        push_frame(PAY1, 8'h04, 4'd8);
        run_until_done(200, 0);
        check("t1_xfers", 64'(n_xfer - x0), 64'd8);

        // 2: two-beat frame with garbage above count*16; first-valid latency
        x0 = n_xfer;
        push_frame({96'hFFFF_0000_5555_AAAA_1111_2222, 32'h1234_ABCD}, 8'h01, 4'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_in);
            #2;
            if (!fifo_empty) break;
        end
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in);
            #2;
            lat++;
            if (data_out_valid) break;
        end
        check("t2_latency", 64'(lat), 64'd3);
        run_until_done(200, 0);
        check("t2_xfers", 64'(n_xfer - x0), 64'd2);

        // 3: same frame as 1 with ready 1,0,0 repeating
        x0 = n_xfer;
        push_frame(PAY1, 8'h04, 4'd8);
        run_until_done(300, 1);
        check("t3_xfers", 64'(n_xfer - x0), 64'd8);

        // 4: malformed entries then a good frame
        x0 = n_xfer;
        e0 = n_err;
        push_frame(PAY1, 8'h00, 4'd4);
        push_frame(PAY1, 8'h03, 4'd4);
        push_frame(PAY1, 8'h10, 4'd0);
        push_frame(PAY1, 8'h10, 4'd9);
        push_frame(PAY1, 8'h80, 4'd3);
        run_until_done(400, 0);
        check("t4_err_pulses", 64'(n_err - e0), 64'd4);
        check("t4_xfers", 64'(n_xfer - x0), 64'd3);

        // 5: two frames back to back, one pop each
        p0 = n_pop;
        x0 = n_xfer;
        push_frame(PAY1, 8'h02, 4'd5);
        push_frame(~PAY1, 8'h40, 4'd7);
        run_until_done(400, 0);
        check("t5_pops", 64'(n_pop - p0), 64'd2);
        check("t5_xfers", 64'(n_xfer - x0), 64'd12);

        // 6: reset after three of eight beats
        x0 = n_xfer;
        push_frame(PAY1, 8'h08, 4'd8);
        for (int i = 0; i < 100 && (n_xfer - x0) < 3; i++) @(posedge clk_in);
        #1;
        data_out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk_in);
        #2;
        check_all_zero("t6_reset");
        exp_q.delete();
        data_out_ready = 1'b1;
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        repeat (15) @(posedge clk_in);
        #2;
        check("t6_xfers", 64'(n_xfer - x0), 64'd3);
        check("t6_busy", 64'(busy), 64'd0);

        // Random frames: mostly legal, some malformed, random backpressure
        for (int f = 0; f < 40; f++) begin
            pay = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 9) < 8) begin
                rch  = 8'(1 << $urandom_range(0, 7));
                rcnt = 4'($urandom_range(1, 8));
            end else begin
                rch  = 8'($urandom_range(0, 255));
                rcnt = 4'($urandom_range(0, 15));
            end
            push_frame(pay, rch, rcnt);
            if (f % 4 == 3) run_until_done(2000, 2);
        end
        run_until_done(2000, 2);
        check("final_err_total", 64'(n_err), 64'(exp_err));
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
